// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the bus arbiter and future interconnect blocks.
// Contents: the HTRANS encoding, the arbiter FSM state type, the hold counter width,
// and helpers that classify a transfer type.
package ahb_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    StPark   = 2'b00,
    StOwn    = 2'b01,
    StLocked = 2'b10
  } arb_state_t;

  // Wide enough for the largest supported hold limit (255).
  localparam int unsigned HoldCntW = 8;

  // A beat that moves data and so counts against the owner's hold budget.
  function automatic logic is_data_beat(htrans_t t);
    return (t == TransNonseq) || (t == TransSeq);
  endfunction

  // Transfer types at which a burst may be cut without splitting it mid-SEQ.
  function automatic logic is_burst_boundary(htrans_t t);
    return (t == TransIdle) || (t == TransNonseq);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: finds the first set bit of req_i searching upward from
// start_i and wrapping around to bit 0.
// Ports:
//   req_i   - request vector
//   start_i - index searched first
//   valid_o - at least one request is set
//   idx_o   - index of the winning request (0 when valid_o is low)
module rr_priority_pick #(
  parameter int unsigned Width = 4
) (
  input  logic [Width-1:0]         req_i,
  input  logic [$clog2(Width)-1:0] start_i,
  output logic                     valid_o,
  output logic [$clog2(Width)-1:0] idx_o
);

  localparam int unsigned IdxW = $clog2(Width);

  // Two ascending passes: start_i..Width-1 first, then 0..start_i-1.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int unsigned i = 0; i < Width; i++) begin
      if (!valid_o && req_i[i] && (IdxW'(i) >= start_i)) begin
        valid_o = 1'b1;
        idx_o   = IdxW'(i);
      end
    end
    for (int unsigned i = 0; i < Width; i++) begin
      if (!valid_o && req_i[i] && (IdxW'(i) < start_i)) begin
        valid_o = 1'b1;
        idx_o   = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter with a burst-hold limit, HLOCK support and bus parking.
// Ports:
//   HCLK, HRESET - clock and synchronous active-high reset
//   HBUSREQ      - per-master bus request
//   HLOCK        - per-master locked-access request
//   HTRANS       - current transfer type on the bus
//   HREADY       - transfer completion; all arbitration state only moves when high
//   HGRANT       - registered one-hot grant
//   HMASTER      - registered index of the master owning the address phase
//   HMASTLOCK    - registered locked-transfer qualifier for the address phase
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned MAX_HOLD       = 16
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [NUM_MASTERS-1:0]         HBUSREQ,
  input  logic [NUM_MASTERS-1:0]         HLOCK,
  input  logic [1:0]                     HTRANS,
  input  logic                           HREADY,
  output logic [NUM_MASTERS-1:0]         HGRANT,
  output logic [$clog2(NUM_MASTERS)-1:0] HMASTER,
  output logic                           HMASTLOCK
);

  localparam int unsigned IdxW = $clog2(NUM_MASTERS);
  localparam logic [IdxW-1:0]        DefIdx   = IdxW'(DEFAULT_MASTER);
  localparam logic [IdxW-1:0]        LastIdx  = IdxW'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0] GrantLsb = NUM_MASTERS'(1);
  localparam logic [HoldCntW-1:0]    MaxHold  = HoldCntW'(MAX_HOLD);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IdxW-1:0]        owner_q, owner_d;
  logic [IdxW-1:0]        rr_last_q, rr_last_d;
  logic [IdxW-1:0]        hmaster_q, hmaster_d;
  logic                   hmastlock_q, hmastlock_d;
  logic [HoldCntW-1:0]    hold_cnt_q, hold_cnt_d;
  // Set once HLOCK has dropped: the final locked transfer is still completing.
  logic                   tail_q, tail_d;

  htrans_t         trans;
  logic [IdxW-1:0] pick_start, pick_idx;
  logic            pick_valid;
  logic            owner_req, owner_lock, others_req, hold_expired, normal_arb, arb;

  assign trans        = htrans_t'(HTRANS);
  assign owner_req    = HBUSREQ[owner_q];
  assign owner_lock   = HLOCK[owner_q];
  assign others_req   = |(HBUSREQ & ~grant_q);
  assign hold_expired = (hold_cnt_q >= MaxHold) && others_req && is_burst_boundary(trans);
  assign normal_arb   = !owner_req || hold_expired;
  assign pick_start   = (rr_last_q == LastIdx) ? '0 : rr_last_q + IdxW'(1);

  rr_priority_pick #(
    .Width(NUM_MASTERS)
  ) u_pick (
    .req_i  (HBUSREQ),
    .start_i(pick_start),
    .valid_o(pick_valid),
    .idx_o  (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_last_d   = rr_last_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    hold_cnt_d  = hold_cnt_q;
    tail_d      = tail_q;
    arb         = 1'b0;

    if (HREADY) begin
      // Address phase follows the grant that was already on the bus this cycle.
      hmaster_d   = owner_q;
      hmastlock_d = owner_lock && (state_q == StLocked);

      case (state_q)
        StPark: arb = 1'b1;
        StOwn:  arb = normal_arb;
        StLocked: begin
          if (owner_lock) begin
            tail_d = 1'b0;
          end else if (!tail_q) begin
            tail_d = 1'b1;
          end else if (normal_arb) begin
            arb = 1'b1;
          end else begin
            state_d = StOwn;
            tail_d  = 1'b0;
          end
        end
        default: arb = 1'b1;
      endcase

      if ((state_q == StOwn) && is_data_beat(trans) && (hold_cnt_q < MaxHold)) begin
        hold_cnt_d = hold_cnt_q + HoldCntW'(1);
      end

      if (arb) begin
        tail_d = 1'b0;
        if (pick_valid) begin
          owner_d   = pick_idx;
          rr_last_d = pick_idx;
          state_d   = HLOCK[pick_idx] ? StLocked : StOwn;
        end else begin
          owner_d = DefIdx;
          state_d = StPark;
        end
        grant_d = GrantLsb << owner_d;
        if (owner_d != owner_q) begin
          hold_cnt_d = '0;
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= StPark;
      grant_q     <= GrantLsb << DefIdx;
      owner_q     <= DefIdx;
      rr_last_q   <= DefIdx;
      hmaster_q   <= DefIdx;
      hmastlock_q <= 1'b0;
      hold_cnt_q  <= '0;
      tail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_last_q   <= rr_last_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
      hold_cnt_q  <= hold_cnt_d;
      tail_q      <= tail_d;
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter (4 masters, default master 0, hold limit 4).
module tb_ahb_bus_arbiter;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [3:0] HBUSREQ;
  logic [3:0] HLOCK;
  logic [1:0] HTRANS;
  logic       HREADY;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER;
  logic       HMASTLOCK;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] IDLE = 2'd0, NONSEQ = 2'd2, SEQ = 2'd3;

  ahb_bus_arbiter #(
    .NUM_MASTERS   (4),
    .DEFAULT_MASTER(0),
    .MAX_HOLD      (4)
  ) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .HBUSREQ  (HBUSREQ),
    .HLOCK    (HLOCK),
    .HTRANS   (HTRANS),
    .HREADY   (HREADY),
    .HGRANT   (HGRANT),
    .HMASTER  (HMASTER),
    .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample just after it; grant must stay one-hot.
  task automatic tick();
    @(posedge HCLK);
    #1;
    check("onehot", 32'($onehot(HGRANT)), 32'd1);
  endtask

  int unsigned rr_order [4] = '{2, 3, 0, 1};
  int unsigned prev;

  initial begin
    // Reset and park
    HRESET = 1'b1; HBUSREQ = 4'b1010; HLOCK = 4'b0000; HTRANS = IDLE; HREADY = 1'b1;
    repeat (3) tick();
    check("rst_grant", HGRANT, 4'b0001);
    check("rst_hmaster", HMASTER, 2'd0);
    check("rst_hmastlock", HMASTLOCK, 1'b0);
    HRESET = 1'b0;
    tick();
    check("park_grant", HGRANT, 4'b0010);
    check("park_hmaster_lag", HMASTER, 2'd0);
    tick();
    check("park_hmaster", HMASTER, 2'd1);

    // Round-robin: all request, owner moves on after 4 data beats
    HBUSREQ = 4'b1111; HTRANS = NONSEQ;
    prev = 1;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        check("rr_hold", HGRANT, 32'd1 << prev);
      end
      tick();
      check("rr_grant", HGRANT, 32'd1 << rr_order[i]);
      check("rr_hmaster_lag", HMASTER, prev);
      prev = rr_order[i];
    end

    // Hold limit: M2 16-beat INCR burst while M3 requests
    HBUSREQ = 4'b0100; HTRANS = IDLE;
    tick();
    check("hold_to_m2", HGRANT, 4'b0100);
    HBUSREQ = 4'b1100;
    for (int b = 0; b < 16; b++) begin
      HTRANS = (b == 0) ? NONSEQ : SEQ;
      tick();
      check("hold_burst_kept", HGRANT, 4'b0100);
    end
    HTRANS = IDLE;
    tick();
    check("hold_to_m3", HGRANT, 4'b1000);
    check("hold_hmaster", HMASTER, 2'd2);

    // Wait states: M3 drops request while HREADY low
    HBUSREQ = 4'b0001; HREADY = 1'b0;
    for (int w = 0; w < 5; w++) begin
      tick();
      check("wait_grant_frozen", HGRANT, 4'b1000);
      check("wait_hmaster_frozen", HMASTER, 2'd2);
    end
    HREADY = 1'b1;
    tick();
    check("wait_handover", HGRANT, 4'b0001);
    check("wait_hmaster", HMASTER, 2'd3);

    // Locked sequence by M1 while M0 and M2 request
    HBUSREQ = 4'b0110; HLOCK = 4'b0010; HTRANS = NONSEQ;
    tick();
    check("lock_grant", HGRANT, 4'b0010);
    check("lock_hmastlock_pre", HMASTLOCK, 1'b0);
    HBUSREQ = 4'b0111;
    for (int t = 0; t < 3; t++) begin
      tick();
      check("lock_grant_held", HGRANT, 4'b0010);
      check("lock_hmastlock", HMASTLOCK, 1'b1);
      check("lock_hmaster", HMASTER, 2'd1);
    end
    HBUSREQ = 4'b0101; HLOCK = 4'b0000;
    tick();
    check("lock_final_transfer", HGRANT, 4'b0010);
    check("lock_hmastlock_drop", HMASTLOCK, 1'b0);
    tick();
    check("lock_release_rr", HGRANT, 4'b0100);

    // Reset during M3 locked burst
    HBUSREQ = 4'b1000; HLOCK = 4'b1000; HTRANS = IDLE;
    tick();
    check("m3_lock_grant", HGRANT, 4'b1000);
    HTRANS = NONSEQ;
    tick();
    check("m3_hmastlock", HMASTLOCK, 1'b1);
    check("m3_hmaster", HMASTER, 2'd3);
    HTRANS = SEQ; HRESET = 1'b1;
    tick();
    check("midrst_grant", HGRANT, 4'b0001);
    check("midrst_hmaster", HMASTER, 2'd0);
    check("midrst_hmastlock", HMASTLOCK, 1'b0);
    HRESET = 1'b0; HBUSREQ = 4'b0000; HLOCK = 4'b0000; HTRANS = IDLE;
    tick();
    check("idle_park", HGRANT, 4'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
